// File: rtl/bm_pkg.sv
// Types and constants shared by the block-matching cost stage and the minimum finder.
package bm_pkg;

  typedef struct packed {
    logic [7:0] v;
    logic [7:0] h;
  } coords_t;

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;

  localparam int DRAIN_CYCLES = 2;
  localparam int PIPE_LAT     = 3;

endpackage

// File: rtl/popcount_tree.sv
// Two registered stages: per-16-bit-slice popcounts, then a saturating total.
// The data word and a sideband word travel with the count so all outputs stay aligned.
module popcount_tree #(
  parameter int WIDTH  = 256,
  parameter int LOG_W  = $clog2(WIDTH),
  parameter int SIDE_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WIDTH-1:0]  i_data,
  input  logic [SIDE_W-1:0] i_side,
  input  logic              i_valid,
  output logic [WIDTH-1:0]  o_data,
  output logic [SIDE_W-1:0] o_side,
  output logic [7:0]        o_sum,
  output logic              o_valid
);

  localparam int N_SLICE = WIDTH / 16;
  localparam int TOT_W   = LOG_W + 1;

  logic [N_SLICE-1:0][4:0] w_part;
  logic [N_SLICE-1:0][4:0] r_part;
  logic [WIDTH-1:0]        r_data;
  logic [SIDE_W-1:0]       r_side;
  logic                    r_valid;
  logic [TOT_W-1:0]        w_total;
  logic [7:0]              w_sum;

  // Each slice count is at most 16, so 5 bits suffice; the adder chain is unrolled per slice.
  for (genvar s = 0; s < N_SLICE; s++) begin : g_slice
    logic [TOT_W-1:0] w_acc;
    assign w_part[s] = 5'($countones(i_data[s*16 +: 16]));
    if (s == 0) begin : g_first
      assign w_acc = TOT_W'(r_part[s]);
    end else begin : g_next
      assign w_acc = g_slice[s-1].w_acc + TOT_W'(r_part[s]);
    end
  end

  assign w_total = g_slice[N_SLICE-1].w_acc;

  if (TOT_W > 8) begin : g_sat
    assign w_sum = (w_total > TOT_W'(255)) ? 8'hFF : w_total[7:0];
  end else begin : g_nosat
    assign w_sum = 8'(w_total);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_part  <= '0;
      r_data  <= '0;
      r_side  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_part <= w_part;
        r_data <= i_data;
        r_side <= i_side;
      end
    end
  end

  // Outputs only move on a valid result, so they hold between results.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_data  <= '0;
      o_side  <= '0;
      o_sum   <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= r_valid;
      if (r_valid) begin
        o_data <= r_data;
        o_side <= r_side;
        o_sum  <= w_sum;
      end
    end
  end

endmodule

// File: rtl/hamming_cost_pipe.sv
// Hamming cost stage: holds one reference census block and streams XOR/popcount
// results with search coordinates for every candidate, 3 cycles after acceptance.
module hamming_cost_pipe
  import bm_pkg::*;
#(
  parameter int blk_size   = 256,
  parameter int n_h_pos    = 48,
  parameter int n_v_pos    = 1,
  parameter int blk_sz_log = $clog2(blk_size)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [blk_size-1:0] ref_blk,
  input  logic [15:0]         ref_blk_index,
  input  logic                ref_load,
  output logic                ref_ready,
  input  logic [blk_size-1:0] cand_blk,
  input  logic                cand_valid,
  output logic                cand_ready,
  output logic [blk_size-1:0] xors,
  output logic [7:0]          sum,
  output logic [15:0]         out_coords,
  output logic [15:0]         blk_index_o,
  output logic                sum_valid
);

  localparam logic [7:0] H_LAST     = 8'(n_h_pos - 1);
  localparam logic [7:0] V_LAST     = 8'(n_v_pos - 1);
  localparam logic [1:0] DRAIN_LAST = 2'(DRAIN_CYCLES - 1);

  state_t              r_state;
  logic [7:0]          r_hCnt;
  logic [7:0]          r_vCnt;
  logic [1:0]          r_drainCnt;
  logic                r_refReady;
  logic                r_candReady;
  logic [blk_size-1:0] r_refBlk;
  logic [15:0]         r_refIdx;
  logic                r_s1Valid;
  logic [blk_size-1:0] r_s1Xors;
  logic [31:0]         r_s1Side;
  logic                w_accept;
  coords_t             w_coords;
  logic [31:0]         w_sideOut;

  assign ref_ready  = r_refReady;
  assign cand_ready = r_candReady;
  assign w_accept   = cand_valid & r_candReady;
  assign w_coords   = '{v: r_vCnt, h: r_hCnt};

  // The reference is only captured in IDLE, so results still in flight keep their reference.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_hCnt      <= H_LAST;
      r_vCnt      <= '0;
      r_drainCnt  <= '0;
      r_refReady  <= 1'b1;
      r_candReady <= 1'b0;
      r_refBlk    <= '0;
      r_refIdx    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (ref_load) begin
            r_refBlk    <= ref_blk;
            r_refIdx    <= ref_blk_index;
            r_state     <= SWEEP;
            r_refReady  <= 1'b0;
            r_candReady <= 1'b1;
          end
        end
        SWEEP: begin
          if (cand_valid) begin
            if (r_hCnt != 8'd0) begin
              r_hCnt <= r_hCnt - 8'd1;
            end else begin
              r_hCnt <= H_LAST;
              if (r_vCnt == V_LAST) begin
                r_vCnt      <= '0;
                r_drainCnt  <= '0;
                r_state     <= DRAIN;
                r_candReady <= 1'b0;
              end else begin
                r_vCnt <= r_vCnt + 8'd1;
              end
            end
          end
        end
        DRAIN: begin
          r_drainCnt <= r_drainCnt + 2'd1;
          if (r_drainCnt == DRAIN_LAST) begin
            r_state    <= IDLE;
            r_refReady <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1Valid <= 1'b0;
      r_s1Xors  <= '0;
      r_s1Side  <= '0;
    end else begin
      r_s1Valid <= w_accept;
      if (w_accept) begin
        r_s1Xors <= r_refBlk ^ cand_blk;
        r_s1Side <= {w_coords, r_refIdx};
      end
    end
  end

  popcount_tree #(
    .WIDTH (blk_size),
    .LOG_W (blk_sz_log),
    .SIDE_W(32)
  ) u_popcount (
    .clk    (clk),
    .reset_n(reset_n),
    .i_data (r_s1Xors),
    .i_side (r_s1Side),
    .i_valid(r_s1Valid),
    .o_data (xors),
    .o_side (w_sideOut),
    .o_sum  (sum),
    .o_valid(sum_valid)
  );

  assign out_coords  = w_sideOut[31:16];
  assign blk_index_o = w_sideOut[15:0];

endmodule

// File: tb/tb_hamming_cost_pipe.sv
// Bench for hamming_cost_pipe: a 48x1 window on 256-bit blocks and a 4x2 window on
// 16-bit blocks share one stimulus stream and are compared every cycle with a model.
`timescale 1ns/1ps
module tb_hamming_cost_pipe;
  import bm_pkg::*;

  localparam int NH0 = 48;
  localparam int NV0 = 1;
  localparam int NH1 = 4;
  localparam int NV1 = 2;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [255:0] ref_blk = '0;
  logic [255:0] cand_blk = '0;
  logic [15:0]  ref_blk_index = '0;
  logic         ref_load = 1'b0;
  logic         cand_valid = 1'b0;

  logic         ref_ready0, cand_ready0, sum_valid0;
  logic [255:0] xors0;
  logic [7:0]   sum0;
  logic [15:0]  coords0, idx0;
  logic         ref_ready1, cand_ready1, sum_valid1;
  logic [15:0]  xors1;
  logic [7:0]   sum1;
  logic [15:0]  coords1, idx1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hamming_cost_pipe #(.blk_size(256), .n_h_pos(NH0), .n_v_pos(NV0)) dut0 (
    .clk(clk), .reset_n(reset_n), .ref_blk(ref_blk), .ref_blk_index(ref_blk_index),
    .ref_load(ref_load), .ref_ready(ref_ready0), .cand_blk(cand_blk), .cand_valid(cand_valid),
    .cand_ready(cand_ready0), .xors(xors0), .sum(sum0), .out_coords(coords0),
    .blk_index_o(idx0), .sum_valid(sum_valid0));

  hamming_cost_pipe #(.blk_size(16), .n_h_pos(NH1), .n_v_pos(NV1)) dut1 (
    .clk(clk), .reset_n(reset_n), .ref_blk(ref_blk[15:0]), .ref_blk_index(ref_blk_index),
    .ref_load(ref_load), .ref_ready(ref_ready1), .cand_blk(cand_blk[15:0]), .cand_valid(cand_valid),
    .cand_ready(cand_ready1), .xors(xors1), .sum(sum1), .out_coords(coords1),
    .blk_index_o(idx1), .sum_valid(sum_valid1));

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic ld, input logic [255:0] rb, input logic [15:0] ri,
                               input logic cv, input logic [255:0] cb);
    @(posedge clk);
    #1;
    ref_load      = ld;
    ref_blk       = rb;
    ref_blk_index = ri;
    cand_valid    = cv;
    cand_blk      = cb;
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // Behavioural model: phase per instance, k-th accepted candidate maps to coordinates
  // by division, and results emerge PIPE_LAT cycles after acceptance.
  typedef struct {
    logic         v;
    logic [255:0] x;
    logic [7:0]   s;
    logic [15:0]  c;
    logic [15:0]  idx;
  } res_t;

  res_t         mS1[2], mS2[2], mOut[2];
  int           mPhase[2], mK[2], mD[2];
  logic [255:0] mRef[2];
  logic [15:0]  mRefIdx[2];
  int           edgeCnt = 0;
  logic         latArm = 1'b0, latWait = 1'b0;
  int           acceptEdge = -100, resEdge = -200;

  function automatic logic [255:0] maskOf(input int i);
    return (i == 0) ? {256{1'b1}} : 256'hFFFF;
  endfunction

  function automatic res_t predict(input int i, input int k, input logic [255:0] cand);
    res_t r;
    int nh, ones;
    nh    = (i == 0) ? NH0 : NH1;
    r.v   = 1'b1;
    r.x   = (mRef[i] ^ cand) & maskOf(i);
    ones  = $countones(r.x);
    r.s   = (ones > 255) ? 8'd255 : 8'(ones);
    r.c   = {8'(k / nh), 8'(nh - 1 - (k % nh))};
    r.idx = mRefIdx[i];
    return r;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        mPhase[i] = 0; mK[i] = 0; mD[i] = 0;
        mS1[i] = '{v: 1'b0, x: '0, s: '0, c: '0, idx: '0};
        mS2[i] = mS1[i];
        mOut[i] = mS1[i];
      end
    end else begin
      edgeCnt++;
      for (int i = 0; i < 2; i++) begin
        if (mS2[i].v) mOut[i] = mS2[i];
        else mOut[i].v = 1'b0;
        mS2[i] = mS1[i];
        mS1[i].v = 1'b0;
        case (mPhase[i])
          0: if (ref_load) begin
               mRef[i] = ref_blk & maskOf(i);
               mRefIdx[i] = ref_blk_index;
               mPhase[i] = 1;
               mK[i] = 0;
             end
          1: if (cand_valid) begin
               mS1[i] = predict(i, mK[i], cand_blk);
               if (i == 0 && latArm) begin
                 acceptEdge = edgeCnt;
                 latArm = 1'b0;
                 latWait = 1'b1;
               end
               mK[i]++;
               if (mK[i] == ((i == 0) ? NH0 * NV0 : NH1 * NV1)) begin
                 mPhase[i] = 2;
                 mD[i] = 0;
               end
             end
          default: begin
            mD[i]++;
            if (mD[i] == DRAIN_CYCLES) mPhase[i] = 0;
          end
        endcase
      end
    end
  end

  logic [15:0]  obsC0[$], obsC1[$];
  logic [7:0]   obsS0[$];
  logic [255:0] obsX0[$];
  logic         haveLast0 = 1'b0;
  logic [15:0]  lastC0 = '0;
  int           lastEdge0 = 0;
  int           gapSeen = 0;

  task automatic cmpInst(input string tag, input int i, input logic sv, input logic [255:0] x,
                         input logic [7:0] s, input logic [15:0] c, input logic [15:0] idx,
                         input logic rr, input logic cr);
    checkOutput({tag, ".sum_valid"}, sv, mOut[i].v);
    checkOutput({tag, ".xors"}, x, mOut[i].x);
    checkOutput({tag, ".sum"}, s, mOut[i].s);
    checkOutput({tag, ".out_coords"}, c, mOut[i].c);
    checkOutput({tag, ".blk_index_o"}, idx, mOut[i].idx);
    checkOutput({tag, ".ref_ready"}, rr, mPhase[i] == 0);
    checkOutput({tag, ".cand_ready"}, cr, mPhase[i] == 1);
  endtask

  always @(negedge clk) begin
    cmpInst("dut0", 0, sum_valid0, xors0, sum0, coords0, idx0, ref_ready0, cand_ready0);
    cmpInst("dut1", 1, sum_valid1, {240'b0, xors1}, sum1, coords1, idx1, ref_ready1, cand_ready1);
    if (sum_valid0) begin
      obsC0.push_back(coords0);
      obsS0.push_back(sum0);
      obsX0.push_back(xors0);
      if (haveLast0 && lastC0 == 16'h0000 && coords0 == 16'h002F) begin
        checkOutput("blockGap", (edgeCnt - lastEdge0 - 1) >= 3, 1);
        gapSeen++;
      end
      haveLast0 = 1'b1;
      lastC0 = coords0;
      lastEdge0 = edgeCnt;
      if (latWait) begin
        resEdge = edgeCnt;
        latWait = 1'b0;
      end
    end
    if (sum_valid1) obsC1.push_back(coords1);
  end

  initial begin
    logic [255:0] ones, rr;
    logic [15:0]  exp1 [8];
    logic [15:0]  q16;
    logic [7:0]   q8;
    logic [255:0] q256;
    int           sent, guard, bad;
    logic         cv;

    ones = '1;
    exp1 = '{16'h0003, 16'h0002, 16'h0001, 16'h0000, 16'h0103, 16'h0102, 16'h0101, 16'h0100};

    repeat (2) applyStimulus(1'b0, '0, '0, 1'b0, '0);
    checkOutput("rstRefReady", ref_ready0, 1);
    checkOutput("rstCandReady", cand_ready0, 0);
    checkOutput("rstSumValid", sum_valid0, 0);
    checkOutput("rstSum", sum0, 0);
    checkOutput("rstXors", xors0, 0);
    checkOutput("rstCoords", coords0, 0);
    checkOutput("rstIdx", idx0, 0);
    reset_n = 1'b1;
    repeat (2) applyStimulus(1'b0, '0, '0, 1'b0, '0);

    $display("[TB] zero reference, 48 zero candidates");
    obsC0.delete(); obsC1.delete(); obsS0.delete(); obsX0.delete();
    latArm = 1'b1;
    applyStimulus(1'b1, '0, 16'h0012, 1'b0, '0);
    repeat (48) applyStimulus(1'b0, '0, '0, 1'b1, '0);
    repeat (6) applyStimulus(1'b0, '0, '0, 1'b0, '0);
    checkOutput("s1Count", obsC0.size(), 48);
    q16 = 16'hDEAD; if (obsC0.size() > 0) q16 = obsC0[0];
    checkOutput("s1FirstCoord", q16, 16'h002F);
    q16 = 16'hDEAD; if (obsC0.size() >= 48) q16 = obsC0[47];
    checkOutput("s1LastCoord", q16, 16'h0000);
    checkOutput("s1Latency", resEdge - acceptEdge + 1, PIPE_LAT);
    checkOutput("dut1Count", obsC1.size(), 8);
    for (int j = 0; j < 8; j++) begin
      q16 = 16'hDEAD; if (j < obsC1.size()) q16 = obsC1[j];
      checkOutput("dut1Coord", q16, exp1[j]);
    end

    $display("[TB] all-ones reference, saturation and 7-bit difference");
    obsC0.delete(); obsS0.delete(); obsX0.delete();
    applyStimulus(1'b1, ones, 16'h0034, 1'b0, '0);
    applyStimulus(1'b0, ones, '0, 1'b1, '0);
    applyStimulus(1'b0, ones, '0, 1'b1, ones ^ 256'h7F);
    repeat (46) applyStimulus(1'b0, ones, '0, 1'b1, rand256());
    repeat (6) applyStimulus(1'b0, '0, '0, 1'b0, '0);
    checkOutput("s2Count", obsC0.size(), 48);
    q8 = 8'hAA; if (obsS0.size() > 0) q8 = obsS0[0];
    checkOutput("s2SatSum", q8, 8'd255);
    q256 = '0; if (obsX0.size() > 0) q256 = obsX0[0];
    checkOutput("s2SatXors", q256, ones);
    q8 = 8'hAA; if (obsS0.size() > 1) q8 = obsS0[1];
    checkOutput("s2Sum7", q8, 8'd7);
    q256 = '0; if (obsX0.size() > 1) q256 = obsX0[1];
    checkOutput("s2Xors7", q256, 256'h7F);

    $display("[TB] random bubbles during a sweep");
    obsC0.delete();
    rr = rand256();
    applyStimulus(1'b1, rr, 16'h0A5A, 1'b0, '0);
    sent = 0; guard = 0;
    while (sent < 48 && guard < 1000) begin
      cv = ($urandom_range(0, 2) != 0);
      if (cv) sent++;
      guard++;
      applyStimulus(1'b0, rr, '0, cv, rand256());
    end
    repeat (6) applyStimulus(1'b0, '0, '0, 1'b0, '0);
    checkOutput("s3Count", obsC0.size(), 48);
    bad = 0;
    for (int j = 0; j < obsC0.size(); j++) if (obsC0[j] !== {8'h00, 8'(47 - j)}) bad++;
    checkOutput("s3CoordSeq", bad, 0);

    $display("[TB] back-to-back blocks with ref_load held");
    obsC0.delete();
    gapSeen = 0;
    rr = rand256();
    repeat (102) applyStimulus(1'b1, rr, 16'h0056, 1'b1, rand256());
    repeat (6) applyStimulus(1'b0, '0, '0, 1'b0, '0);
    checkOutput("s4Count", obsC0.size(), 96);
    checkOutput("s4GapSeen", gapSeen > 0, 1);

    $display("[TB] asynchronous reset mid-sweep");
    rr = rand256();
    applyStimulus(1'b1, rr, 16'h0078, 1'b0, '0);
    for (int j = 0; j < 10; j++) applyStimulus(1'b0, rr, '0, 1'b1, rand256());
    #2 reset_n = 1'b0;
    #1;
    checkOutput("s5SumValid", sum_valid0, 0);
    checkOutput("s5Sum", sum0, 0);
    checkOutput("s5Xors", xors0, 0);
    checkOutput("s5Coords", coords0, 0);
    checkOutput("s5Idx", idx0, 0);
    checkOutput("s5RefReady", ref_ready0, 1);
    checkOutput("s5CandReady", cand_ready0, 0);
    obsC0.delete();
    ref_load = 1'b0;
    cand_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (8) applyStimulus(1'b0, '0, '0, 1'b0, '0);
    checkOutput("s5NoResults", obsC0.size(), 0);

    $display("[TB] full sweep after reset");
    obsC0.delete();
    rr = rand256();
    applyStimulus(1'b1, rr, 16'h00C3, 1'b0, '0);
    repeat (48) applyStimulus(1'b0, rr, '0, 1'b1, rand256());
    repeat (6) applyStimulus(1'b0, '0, '0, 1'b0, '0);
    checkOutput("s6Count", obsC0.size(), 48);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
